// File: rtl/rrf_freelist_manager.sv
// Rename-register-file free-list manager: hands out up to two destination tags per cycle,
// reclaims retired tags, and rewinds on misprediction. Macro RRF_FREELIST_BYPASS_EN enables same-cycle reuse.
`ifndef RRF_NUM
`define RRF_NUM 64
`endif
`ifndef RRF_SEL
`define RRF_SEL 6
`endif

module rrf_freelist_manager #(
    parameter int RRF_NUM = `RRF_NUM,
    parameter int RRF_SEL = `RRF_SEL
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic               stall_dp_i,
    input  logic [1:0]         com_inst_num_i,
    input  logic               prmiss_i,
    output logic [RRF_SEL-1:0] rrftag1_o,
    output logic [RRF_SEL-1:0] rrftag2_o,
    output logic               allocatable_o,
    output logic [RRF_SEL:0]   freenum_o
);

    localparam logic [RRF_SEL:0] FULL_COUNT = (RRF_SEL+1)'(RRF_NUM);

    logic [RRF_SEL-1:0] rrfptr;
    logic [RRF_SEL-1:0] comptr;
    logic [RRF_SEL:0]   freenum;
    logic [1:0]         reqnum;
    logic [1:0]         alloc_num;
    logic [RRF_SEL+1:0] avail;
    logic [RRF_SEL-1:0] comptr_next;

    assign reqnum = {1'b0, req1_i} + {1'b0, req2_i};

    // One extra bit so freenum + commits cannot overflow when bypass is enabled.
`ifdef RRF_FREELIST_BYPASS_EN
    assign avail = {1'b0, freenum} + (RRF_SEL+2)'(com_inst_num_i);
`else
    assign avail = {1'b0, freenum};
`endif

    assign allocatable_o = (avail >= (RRF_SEL+2)'(reqnum));
    assign alloc_num     = (allocatable_o && !stall_dp_i && !prmiss_i) ? reqnum : 2'd0;

    assign rrftag1_o   = rrfptr;
    assign rrftag2_o   = req1_i ? rrfptr + RRF_SEL'(1) : rrfptr;
    assign freenum_o   = freenum;
    assign comptr_next = comptr + RRF_SEL'(com_inst_num_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrfptr  <= '0;
            comptr  <= '0;
            freenum <= FULL_COUNT;
        end else begin
            comptr <= comptr_next;
            // A flush drops every uncommitted tag, so the free list refills completely.
            if (prmiss_i) begin
                rrfptr  <= comptr_next;
                freenum <= FULL_COUNT;
            end else begin
                rrfptr  <= rrfptr + RRF_SEL'(alloc_num);
                freenum <= freenum - (RRF_SEL+1)'(alloc_num) + (RRF_SEL+1)'(com_inst_num_i);
            end
        end
    end

endmodule

// File: tb/tb_rrf_freelist_manager.sv
// Directed bench for rrf_freelist_manager: allocation, wrap, full, bypass, flush, stall and reset.
module tb_rrf_freelist_manager;

    logic       clk = 1'b0;
    logic       reset;
    logic       req1, req2, stall, prmiss;
    logic [1:0] com;
    logic [5:0] tag1, tag2;
    logic       alloc;
    logic [6:0] freenum;

    int n_tests = 0;
    int n_fail  = 0;

    rrf_freelist_manager #(.RRF_NUM(64), .RRF_SEL(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .req1_i         (req1),
        .req2_i         (req2),
        .stall_dp_i     (stall),
        .com_inst_num_i (com),
        .prmiss_i       (prmiss),
        .rrftag1_o      (tag1),
        .rrftag2_o      (tag2),
        .allocatable_o  (alloc),
        .freenum_o      (freenum)
    );

    always #5 clk = ~clk;

    a_com_legal: assert property (@(posedge clk) disable iff (reset) com != 2'd3);
    a_com_bound: assert property (@(posedge clk) disable iff (reset) {5'd0, com} <= 7'd64 - freenum);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic r2, input logic st,
                         input logic [1:0] c, input logic pm);
        req1 = r1; req2 = r2; stall = st; com = c; prmiss = pm;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int coms[5] = '{2, 2, 2, 1, 0};
        reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        #2;
        check("rst_tag1", tag1, 0);
        check("rst_tag2", tag2, 1);
        check("rst_free", freenum, 64);
        check("rst_alloc", alloc, 1);
        drive(0, 0, 0, 0, 0);
        check("rst_tag2_noreq1", tag2, 0);
        cyc();
        reset = 1'b0;

        // three dual allocations after reset
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("dual_tag1", tag1, 2 * i);
            check("dual_tag2", tag2, 2 * i + 1);
            check("dual_free", freenum, 64 - 2 * i);
            cyc();
        end
        check("dual_free_end", freenum, 58);

        // slot-1 only, then slot-2 only with and without stall
        drive(1, 0, 0, 0, 0);
        check("s1_tag1", tag1, 6);
        check("s1_tag2", tag2, 7);
        cyc();
        drive(0, 1, 1, 0, 0);
        check("s2_tag2", tag2, 7);
        cyc();
        check("stall_ptr", tag1, 7);
        check("stall_free", freenum, 57);
        drive(0, 1, 0, 0, 0);
        cyc();
        check("s2_ptr", tag1, 8);
        check("s2_free", freenum, 56);

        // commit alone, then commit concurrent with allocation
        drive(0, 0, 0, 2, 0);
        cyc();
        check("com_free", freenum, 58);
        drive(1, 1, 0, 1, 0);
        cyc();
        check("comalloc_ptr", tag1, 10);
        check("comalloc_free", freenum, 57);

        // reach comptr=10, rrfptr=20 then flush with one commit
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, coms[i][1:0], 0);
            cyc();
        end
        check("pre_flush_ptr", tag1, 20);
        check("pre_flush_free", freenum, 54);
        drive(1, 1, 0, 1, 1);
        cyc();
        check("flush_ptr", tag1, 11);
        check("flush_free", freenum, 64);

        // fill until a single entry is left
        for (int i = 0; i < 31; i++) begin
            drive(1, 1, 0, 0, 0);
            cyc();
        end
        drive(1, 0, 0, 0, 0);
        cyc();
        check("one_left_ptr", tag1, 10);
        check("one_left_free", freenum, 1);
        drive(1, 1, 0, 0, 0);
        check("full_alloc", alloc, 0);
        cyc();
        check("full_ptr", tag1, 10);
        check("full_free", freenum, 1);
        drive(1, 0, 0, 0, 0);
        check("one_fit_alloc", alloc, 1);
        cyc();
        check("empty_ptr", tag1, 11);
        check("empty_free", freenum, 0);

        // empty list: no request always fits, a request needs bypass
        check("empty_req_alloc", alloc, 0);
        drive(0, 0, 0, 0, 0);
        check("empty_noreq_alloc", alloc, 1);
        drive(1, 1, 0, 2, 0);
`ifdef RRF_FREELIST_BYPASS_EN
        check("bypass_alloc", alloc, 1);
        cyc();
        check("bypass_free", freenum, 0);
        check("bypass_ptr", tag1, 13);
`else
        check("bypass_alloc", alloc, 0);
        cyc();
        check("bypass_free", freenum, 2);
        check("bypass_ptr", tag1, 11);
`endif

        // flush with no commit realigns rrfptr to comptr=13
        drive(0, 0, 0, 0, 1);
        cyc();
        check("realign_ptr", tag1, 13);
        check("realign_free", freenum, 64);

        // walk comptr to 1, then allocate up to rrfptr=63 with two left
        drive(1, 1, 0, 0, 0);
        cyc();
        for (int i = 0; i < 25; i++) begin
            drive(1, 1, 0, 2, 0);
            cyc();
        end
        drive(0, 0, 0, 2, 0);
        cyc();
        check("walk_ptr", tag1, 1);
        check("walk_free", freenum, 64);
        for (int i = 0; i < 31; i++) begin
            drive(1, 1, 0, 0, 0);
            cyc();
        end
        check("wrap_tag1", tag1, 63);
        check("wrap_free", freenum, 2);
        drive(1, 1, 0, 0, 0);
        check("wrap_tag2", tag2, 0);
        check("wrap_alloc", alloc, 1);
        cyc();
        check("wrap_next_ptr", tag1, 1);
        check("wrap_next_free", freenum, 0);

        // reset asserted mid-cycle, away from any clock edge
        drive(0, 0, 0, 2, 0);
        cyc();
        check("pre_rst_free", freenum, 2);
        drive(1, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_ptr", tag1, 0);
        check("async_rst_free", freenum, 64);
        cyc();
        reset = 1'b0;
        #1;
        check("post_rst_tag1", tag1, 0);
        check("post_rst_tag2", tag2, 1);
        cyc();
        check("post_rst_ptr", tag1, 2);
        check("post_rst_free", freenum, 62);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
